// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
// State encoding, frame geometry, odd parity and common scancode values.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUS = 3'd1,
        BIT_HIGH = 3'd2,
        BIT_LOW  = 3'd3,
        STOP_GAP = 3'd4
    } ps2_state_e;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bit 0 is the start bit, bit 10 the stop bit.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte-side handshake of the PS/2 transmitter: scancode strobe in, status out.
interface ps2_device_tx_if;
    logic [7:0] scancode;
    logic       send;
    logic       busy;
    logic       overflow;
    logic       host_rts;

    modport master (output scancode, output send, input busy, input overflow, input host_rts);
    modport slave  (input scancode, input send, output busy, output overflow, output host_rts);
endinterface

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with peek-at-head and explicit pop.
// Writes while full are ignored; the caller is responsible for flagging them.
module ps2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] peek,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_wr_s;
    logic        do_pop_s;

    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign do_wr_s  = wr_en & ~full;
    assign do_pop_s = pop & ~empty;
    assign peek     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; write and pop in one cycle both advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= (AW+1)'(0);
            rd_ptr_r <= (AW+1)'(0);
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues scancodes and clocks them out as 11-bit frames.
// Optional host request-to-send detection is compiled in with PS2TX_HOST_RTS_EN.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int PS2_CLK_HZ  = 12_500,
    parameter int FIFO_DEPTH  = 16,
    parameter int GAP_CYCLES  = 2 * (CLK_FREQ_HZ / (2 * PS2_CLK_HZ))
) (
    input  logic           clk,
    input  logic           reset,
    ps2_device_tx_if.slave host,
    input  logic           ps2_clk_i,
    input  logic           ps2_data_i,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    localparam int HALF  = CLK_FREQ_HZ / (2 * PS2_CLK_HZ);
    localparam int CNT_W = $clog2((GAP_CYCLES > HALF) ? GAP_CYCLES : HALF) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    ps2_state_e            state_r;
    ps2_state_e            state_n;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_n;
    logic [3:0]            idx_r;
    logic [3:0]            idx_n;
    logic [1:0]            clk_sync_r;
    logic [1:0]            data_sync_r;
    logic                  sclk_s;
    logic                  sdata_s;
    logic                  pop_s;
    logic [7:0]            head_s;
    logic                  full_s;
    logic                  empty_s;
    logic [FRAME_BITS-1:0] frame_s;
    logic                  clk_oe_r;
    logic                  data_oe_r;
    logic                  busy_r;
    logic                  overflow_r;
    logic                  host_rts_r;
    logic                  clk_oe_n;
    logic                  data_oe_n;
    logic                  busy_n;
    logic                  overflow_n;
    logic                  host_rts_n;
`ifdef PS2TX_HOST_RTS_EN
    logic [CNT_W-1:0]      rts_cnt_r;
    logic [CNT_W-1:0]      rts_cnt_n;
    logic                  rts_seen_r;
    logic                  rts_seen_n;
    logic                  rts_fire_s;
`endif

    assign sclk_s  = clk_sync_r[1];
    assign sdata_s = data_sync_r[1];

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (host.send),
        .wr_data (host.scancode),
        .pop     (pop_s),
        .peek    (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // State, counters, line synchronisers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_W'(0);
            idx_r       <= 4'd0;
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            clk_oe_r    <= 1'b0;
            data_oe_r   <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            host_rts_r  <= 1'b0;
`ifdef PS2TX_HOST_RTS_EN
            rts_cnt_r   <= CNT_W'(0);
            rts_seen_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            idx_r       <= idx_n;
            clk_sync_r  <= {clk_sync_r[0], ps2_clk_i};
            data_sync_r <= {data_sync_r[0], ps2_data_i};
            clk_oe_r    <= clk_oe_n;
            data_oe_r   <= data_oe_n;
            busy_r      <= busy_n;
            overflow_r  <= overflow_n;
            host_rts_r  <= host_rts_n;
`ifdef PS2TX_HOST_RTS_EN
            rts_cnt_r   <= rts_cnt_n;
            rts_seen_r  <= rts_seen_n;
`endif
        end
    end

    // Next-state logic; the head byte is popped only after a completed frame's gap.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        pop_s   = 1'b0;
`ifdef PS2TX_HOST_RTS_EN
        rts_cnt_n  = CNT_W'(0);
        rts_seen_n = (state_r == WAIT_BUS) ? rts_seen_r : 1'b0;
        rts_fire_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_n = CNT_W'(0);
                idx_n = 4'd0;
                if (!empty_s) begin
                    state_n = WAIT_BUS;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT_BUS: begin
                if (sclk_s && sdata_s) begin
                    if (cnt_r == GAP_LAST) begin
                        state_n = BIT_HIGH;
                        cnt_n   = CNT_W'(0);
                        idx_n   = 4'd0;
                    end else begin
                        cnt_n = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_n = CNT_W'(0);
                end
`ifdef PS2TX_HOST_RTS_EN
                // Clock high with data low for HALF cycles is one request; re-armed once data rises.
                if (sclk_s && !sdata_s && !rts_seen_r) begin
                    if (rts_cnt_r == HALF_LAST) begin
                        rts_fire_s = 1'b1;
                        rts_seen_n = 1'b1;
                    end else begin
                        rts_cnt_n = rts_cnt_r + CNT_W'(1);
                    end
                end else if (sdata_s) begin
                    rts_seen_n = 1'b0;
                end else begin
                    rts_seen_n = rts_seen_r;
                end
`endif
            end
            BIT_HIGH: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = CNT_W'(0);
                    if (!sclk_s) begin
                        state_n = WAIT_BUS;
                    end else begin
                        state_n = BIT_LOW;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            BIT_LOW: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = CNT_W'(0);
                    if (idx_r == 4'd10) begin
                        state_n = STOP_GAP;
                    end else begin
                        idx_n   = idx_r + 4'd1;
                        state_n = BIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            STOP_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_n   = CNT_W'(0);
                    pop_s   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_W'(0);
                idx_n   = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the line drives change with the state register.
    always_comb begin
        frame_s    = build_frame(head_s);
        clk_oe_n   = 1'b0;
        data_oe_n  = 1'b0;
        case (state_n)
            BIT_HIGH: begin
                data_oe_n = ~frame_s[idx_n];
            end
            BIT_LOW: begin
                clk_oe_n  = 1'b1;
                data_oe_n = ~frame_s[idx_n];
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
            end
        endcase
        busy_n     = ~empty_s | (state_r != IDLE);
        overflow_n = host.send & full_s;
`ifdef PS2TX_HOST_RTS_EN
        host_rts_n = rts_fire_s;
`else
        host_rts_n = 1'b0;
`endif
    end

    assign ps2_clk_oe    = clk_oe_r;
    assign ps2_data_oe   = data_oe_r;
    assign host.busy     = busy_r;
    assign host.overflow = overflow_r;
    assign host.host_rts = host_rts_r;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: decodes frames from the open-drain lines
// and compares them against hand tables and a frame-rule reference model.
module tb_ps2_device_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int PS2_HZ = 12_500;
    localparam int HALF_C = 40;
    localparam int GAP_C  = 80;
    localparam int DEPTH  = 16;
`ifdef PS2TX_HOST_RTS_EN
    localparam int EXP_RTS = 1;
`else
    localparam int EXP_RTS = 0;
`endif

    typedef struct {
        logic [7:0]  code;
        logic [10:0] frame;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_i;
    logic ps2_data_i;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic host_clk_hold = 1'b0;
    logic host_data_hold = 1'b0;

    ps2_device_tx_if bus ();

    assign ps2_clk_i  = ~(ps2_clk_oe | host_clk_hold);
    assign ps2_data_i = ~(ps2_data_oe | host_data_hold);

    ps2_device_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .PS2_CLK_HZ  (PS2_HZ),
        .FIFO_DEPTH  (DEPTH),
        .GAP_CYCLES  (GAP_C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (bus),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int edges = 0;
    int ovf_pulses = 0;
    int rts_pulses = 0;
    int period_err = 0;
    int frame_err = 0;
    int hi_run = 0;
    int last_run = 0;
    int min_gap = 1000000;
    int last_edge_cyc = 0;
    int nbits = 0;
    logic prev_oe = 1'b0;
    logic [10:0] cur = 11'd0;
    logic [10:0] frames [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock, sampled after the falling edge; also decodes device clock edges into frames.
    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        if (bus.overflow) ovf_pulses++;
        if (bus.host_rts) rts_pulses++;
        if (ps2_clk_i && ps2_data_i) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_run = hi_run;
            hi_run = 0;
        end
        if (reset || host_clk_hold) begin
            nbits = 0;
        end else if (ps2_clk_oe && !prev_oe) begin
            edges++;
            if (nbits == 0) begin
                if (frames.size() > 0 && last_run < min_gap) min_gap = last_run;
            end else if (cyc - last_edge_cyc != 2 * HALF_C) begin
                period_err++;
            end
            last_edge_cyc = cyc;
            cur[nbits] = ps2_data_i;
            nbits++;
            if (nbits == 11) begin
                frames.push_back(cur);
                if (cur[0] != 1'b0 || cur[10] != 1'b1 || (^cur[9:1]) != 1'b1) frame_err++;
                nbits = 0;
            end
        end
        prev_oe = ps2_clk_oe;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.scancode = b;
        bus.send = 1'b1;
        step();
        bus.send = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        repeat (4) step();
        while (bus.busy && n < budget) begin
            step();
            n++;
        end
        check(name, int'(bus.busy), 0);
    endtask

    task automatic wait_bits(input int k, input int budget, input string name);
        int n = 0;
        while (nbits < k && n < budget) begin
            step();
            n++;
        end
        check(name, int'(nbits >= k), 1);
    endtask

    task automatic wait_clk_release(input string name);
        int n = 0;
        while (ps2_clk_oe && n < 200) begin
            step();
            n++;
        end
        check(name, int'(ps2_clk_oe), 0);
    endtask

    vec_t tbl [8];
    logic [7:0] six [6];
    logic [7:0] exp_q [$];

    initial begin
        int f0;
        int e0;
        int o0;
        int r0;
        int tail;
        logic [7:0] code;
        logic [10:0] exp_frame;

        bus.scancode = 8'h00;
        bus.send = 1'b0;

        tbl[0] = '{8'h1C,      11'b1_0_00011100_0};
        tbl[1] = '{8'h5A,      11'b1_1_01011010_0};
        tbl[2] = '{SC_BREAK,   11'b1_1_11110000_0};
        tbl[3] = '{SC_LSHIFT,  11'b1_1_00010010_0};
        tbl[4] = '{8'h00,      11'b1_1_00000000_0};
        tbl[5] = '{8'hFF,      11'b1_1_11111111_0};
        tbl[6] = '{8'h01,      11'b1_0_00000001_0};
        tbl[7] = '{8'h80,      11'b1_0_10000000_0};

        repeat (3) step();
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_data_oe", int'(ps2_data_oe), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_host_rts", int'(bus.host_rts), 0);
        reset = 1'b0;
        repeat (3) step();

        // Single frames from the table, with the busy tail after the last clock pulse.
        for (int i = 0; i < 8; i++) begin
            f0 = frames.size();
            send_byte(tbl[i].code);
            wait_idle(1500, $sformatf("tbl%0d_idle", i));
            tail = cyc - last_edge_cyc;
            check($sformatf("tbl%0d_count", i), frames.size(), f0 + 1);
            if (frames.size() > f0) check($sformatf("tbl%0d_frame", i), int'(frames[f0]), int'(tbl[i].frame));
            check($sformatf("tbl%0d_busy_tail", i),
                  int'(tail >= HALF_C + GAP_C && tail <= HALF_C + GAP_C + 2), 1);
        end

        // Six bytes on consecutive cycles come out in order.
        six[0] = 8'h12; six[1] = 8'h1C; six[2] = 8'hF0;
        six[3] = 8'h1C; six[4] = 8'hF0; six[5] = 8'h12;
        f0 = frames.size();
        bus.send = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.scancode = six[i];
            step();
        end
        bus.send = 1'b0;
        wait_idle(8000, "six_idle");
        check("six_count", frames.size(), f0 + 6);
        for (int i = 0; i < 6; i++) begin
            if (frames.size() > f0 + i) check($sformatf("six_byte%0d", i), int'(frames[f0 + i][8:1]), int'(six[i]));
        end

        // Host inhibit during bit 4 aborts; the same byte is resent afterwards.
        f0 = frames.size();
        send_byte(8'h5A);
        wait_bits(4, 3000, "inh_reach_bit4");
        wait_clk_release("inh_bit4_high");
        repeat (10) step();
        host_clk_hold = 1'b1;
        repeat (60) step();
        check("inh_clk_released", int'(ps2_clk_oe), 0);
        check("inh_data_released", int'(ps2_data_oe), 0);
        e0 = edges;
        repeat (300) step();
        check("inh_no_edges", edges, e0);
        check("inh_no_frame", frames.size(), f0);
        host_clk_hold = 1'b0;
        wait_idle(2000, "inh_idle");
        check("inh_count", frames.size(), f0 + 1);
        if (frames.size() > f0) check("inh_frame", int'(frames[f0]), int'(11'b1_1_01011010_0));

        // Seventeen writes against a 16-deep queue: only the last is dropped.
        f0 = frames.size();
        o0 = ovf_pulses;
        send_byte(8'h40);
        wait_bits(1, 500, "ovf_started");
        bus.send = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.scancode = 8'(i + 1);
            step();
            check($sformatf("ovf_pulse%0d", i), int'(bus.overflow), int'(i == 15));
        end
        bus.send = 1'b0;
        step();
        check("ovf_total", ovf_pulses - o0, 1);
        wait_idle(20000, "ovf_idle");
        check("ovf_count", frames.size(), f0 + 16);
        if (frames.size() >= f0 + 16) begin
            check("ovf_byte0", int'(frames[f0][8:1]), 8'h40);
            for (int k = 1; k < 16; k++) begin
                check($sformatf("ovf_byte%0d", k), int'(frames[f0 + k][8:1]), k);
            end
        end

        // Host holds data low with clock high while a byte is queued.
        f0 = frames.size();
        e0 = edges;
        r0 = rts_pulses;
        host_data_hold = 1'b1;
        send_byte(8'h33);
        repeat (200) step();
        check("rts_pulses", rts_pulses - r0, EXP_RTS);
        check("rts_no_edges", edges, e0);
        host_data_hold = 1'b0;
        wait_idle(2000, "rts_idle");
        check("rts_count", frames.size(), f0 + 1);
        if (frames.size() > f0) check("rts_frame", int'(frames[f0]), int'(11'b1_1_00110011_0));

        // Random bursts against the frame-rule model.
        for (int b = 0; b < 3; b++) begin
            int n;
            n = $urandom_range(1, 4);
            f0 = frames.size();
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                code = 8'($urandom);
                exp_q.push_back(code);
                send_byte(code);
                repeat ($urandom_range(0, 30)) step();
            end
            wait_idle(n * 1200 + 500, $sformatf("rnd%0d_idle", b));
            check($sformatf("rnd%0d_count", b), frames.size(), f0 + n);
            for (int i = 0; i < n; i++) begin
                exp_frame = {1'b1, ~(^exp_q[i]), exp_q[i], 1'b0};
                if (frames.size() > f0 + i) check($sformatf("rnd%0d_frame%0d", b, i), int'(frames[f0 + i]), int'(exp_frame));
            end
        end

        // Reset during bit 6 drops the frame and the queued byte behind it.
        f0 = frames.size();
        send_byte(8'hA5);
        send_byte(8'h3C);
        wait_bits(6, 3000, "rst_reach_bit6");
        wait_clk_release("rst_bit6_high");
        repeat (5) step();
        reset = 1'b1;
        step();
        check("midrst_clk_oe", int'(ps2_clk_oe), 0);
        check("midrst_data_oe", int'(ps2_data_oe), 0);
        check("midrst_busy", int'(bus.busy), 0);
        reset = 1'b0;
        e0 = edges;
        repeat (3000) step();
        check("midrst_no_edges", edges, e0);
        check("midrst_no_frame", frames.size(), f0);
        check("midrst_busy_after", int'(bus.busy), 0);

        check("period_errors", period_err, 0);
        check("frame_errors", frame_err, 0);
        check("min_gap_ok", int'(min_gap >= GAP_C), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
Downstream stage of the ASCII-to-scancode translator. Accepts single-cycle `send`-strobed scancode bytes into a small FIFO. Serialises each byte as a device-side PS/2 frame on open-drain clock/data lines: device generates the clock; frame is start bit, 8 data bits LSB first, odd parity, stop bit. Honours host inhibit (host holding clock low) by aborting and retrying the frame.

Parameters:
CLK_FREQ_HZ, 25_000_000, system clock frequency.
PS2_CLK_HZ, 12_500, PS/2 clock rate; HALF = CLK_FREQ_HZ/(2*PS2_CLK_HZ) cycles, integer divide, must be >= 4.
FIFO_DEPTH, 16, byte FIFO depth; power of 2, >= 4.
GAP_CYCLES, 2*HALF, bus-idle hold after each stop bit and before any frame start.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scancode  in  8  byte to transmit
send  in  1  one-cycle write strobe for scancode
ps2_clk_i  in  1  PS/2 clock line sense (asynchronous)
ps2_data_i  in  1  PS/2 data line sense (asynchronous)
ps2_clk_oe  out  1  1 = pull clock line low; 0 = release
ps2_data_oe  out  1  1 = pull data line low; 0 = release
busy  out  1  FIFO non-empty or frame in progress
overflow  out  1  one-cycle pulse when a send is dropped because the FIFO is full
host_rts  out  1  host request-to-send pulse (optional feature; tied 0 when compiled out)

Behaviour:
- Reset: ps2_clk_oe=0, ps2_data_oe=0, busy=0, overflow=0, host_rts=0; FIFO empty; state IDLE; counters 0. Reset mid-frame releases both lines on the next edge and discards FIFO contents.
- Inputs: ps2_clk_i and ps2_data_i pass through 2-flop synchronisers before any use.
- FIFO write: on send, write scancode if not full. If full, drop the byte and pulse overflow the next cycle. A write and a pop in the same cycle are both honoured.
- Pop rule: the head byte is only peeked during transmission. It is popped at the end of STOP_GAP, so an aborted frame retransmits the same byte.
- IDLE: if the FIFO is non-empty, go to WAIT_BUS.
- WAIT_BUS: count cycles while synced clk=1 and data=1; reset the count on either low. Count = GAP_CYCLES → BIT_HIGH, bit index 0.
- BIT_HIGH (HALF cycles): clock released. On entry, ps2_data_oe = ~frame[idx]. frame = {1'b1 stop, odd parity = ~^byte, byte[7:0], 1'b0 start}, idx 0 = start bit.
- At the last BIT_HIGH cycle, if synced clk=0 (host inhibit): release both lines and go to WAIT_BUS; no pop. Otherwise go to BIT_LOW.
- BIT_LOW (HALF cycles): ps2_clk_oe=1, data held. At the end, idx++. If idx was 10, go to STOP_GAP; otherwise go to BIT_HIGH.
- STOP_GAP: both lines released for GAP_CYCLES, then pop and go to IDLE.
- Host inhibit observed during BIT_LOW is ignored; the line is already low.
- busy = FIFO non-empty OR state ≠ IDLE.
- Each frame produces exactly 11 clock low pulses; clock period = 2*HALF cycles.

Optional Feature:
PS2TX_HOST_RTS_EN. With the macro defined: in WAIT_BUS, synced clk=1 with data=0 held for HALF cycles is a host request-to-send. The block pulses host_rts for one cycle and stays in WAIT_BUS until data returns high; it never transmits while data is held low. Without the macro: host_rts is constant 0, and data=0 only restarts the idle count.

Decomposition:
- Package ps2_pkg: state enum (IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, STOP_GAP), FRAME_BITS=11, odd-parity function, shared scancode constants (8'hF0 break, 8'h12 left shift).
- One sub-module, ps2_byte_fifo: synchronous FIFO with full, empty, peek and pop.

Test Plan:
- CLK_FREQ_HZ=1_000_000, PS2_CLK_HZ=12_500 (HALF=40); send 8'h1C → data sampled on 11 clock falling edges = 0,0,0,1,1,1,0,0,0,0(parity),1; clock period 80 cycles; busy drops after the gap.
- Send 8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12 on consecutive cycles → six frames in order, each separated by ≥ GAP_CYCLES of both lines high.
- Host holds ps2_clk_i low during BIT_HIGH of bit 4 of 8'h5A → lines released, no further edges. After release plus GAP, full frame of 8'h5A resent (parity bit 1).
- Send 17 bytes back-to-back with FIFO_DEPTH=16 while the first is transmitting → exactly one overflow pulse, on the 17th send; 16 frames emitted.
- Assert reset mid-frame (bit 6) → both oe=0 next cycle, busy=0, no frame afterwards.
- With PS2TX_HOST_RTS_EN: ps2_data_i low, clock high for 40 cycles while a byte is queued → single host_rts pulse, no transmission until data rises; then the frame completes.
